// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the two-port program ROM arbiter.
// Used by rom_arbiter and rom_arb_resp.
package rom_arbiter_pkg;

  typedef enum logic [0:0] {
    PRIO_D  = 1'b0,
    PRIO_IF = 1'b1
  } arb_state_t;

  localparam int PORT_IF  = 0;
  localparam int PORT_D   = 1;
  localparam int ESPERA_W = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rom_arb_resp.sv
// Per-port response stage: captures ROM data on a grant cycle and
// raises rvalid for exactly one cycle; rdata holds until the next capture.
module rom_arb_resp
  import rom_arbiter_pkg::*;
#(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [ANCHO-1:0] din,
  output logic             rvalid,
  output logic [ANCHO-1:0] rdata
);

  // capture register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (capture) begin
      rvalid <= 1'b1;
      rdata  <= din;
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Fixed-priority (D first) arbiter for a shared async-read ROM with an IF
// starvation guard. Optional grant/conflict counters under ROM_ARBITER_STATS_EN.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter  int ANCHO      = 32,
  parameter  int LARGO      = 1024,
  parameter  int MAX_ESPERA = 4,
  localparam int AW         = $clog2(LARGO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [ANCHO-1:0] if_rdata,
  input  logic             d_req,
  input  logic [AW-1:0]    d_addr,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [ANCHO-1:0] d_rdata,
  output logic [AW-1:0]    rom_addr,
  input  logic [ANCHO-1:0] rom_dout
`ifdef ROM_ARBITER_STATS_EN
  ,
  output logic [15:0]      stat_if_gnt,
  output logic [15:0]      stat_d_gnt,
  output logic [15:0]      stat_conflict
`endif
);

  localparam logic [ESPERA_W-1:0] ESPERA_MAX = ESPERA_W'(MAX_ESPERA);

  arb_state_t          state_r;
  arb_state_t          state_nxt_s;
  logic [ESPERA_W-1:0] espera_r;
  logic [ESPERA_W-1:0] espera_nxt_s;
  logic [AW-1:0]       last_addr_r;
  logic [AW-1:0]       sel_addr_s;
  logic [1:0]          gnt_s;

  // state, starvation counter and last-granted address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= PRIO_D;
      espera_r    <= '0;
      last_addr_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      espera_r <= espera_nxt_s;
      if (gnt_s != 2'b00) begin
        last_addr_r <= sel_addr_s;
      end else begin
        last_addr_r <= last_addr_r;
      end
    end
  end

  // grant decision and starvation-counter update
  always_comb begin
    gnt_s = 2'b00;
    if (rst) begin
      gnt_s = 2'b00;
    end else if (if_req && d_req) begin
      if (state_r == PRIO_IF) begin
        gnt_s[PORT_IF] = 1'b1;
      end else begin
        gnt_s[PORT_D] = 1'b1;
      end
    end else if (if_req) begin
      gnt_s[PORT_IF] = 1'b1;
    end else if (d_req) begin
      gnt_s[PORT_D] = 1'b1;
    end else begin
      gnt_s = 2'b00;
    end

    espera_nxt_s = '0;
    if (if_req && !gnt_s[PORT_IF]) begin
      if (espera_r >= ESPERA_MAX) begin
        espera_nxt_s = ESPERA_MAX;
      end else begin
        espera_nxt_s = espera_r + {{(ESPERA_W-1){1'b0}}, 1'b1};
      end
    end else begin
      espera_nxt_s = '0;
    end
  end

  // next state: flip to PRIO_IF as the counter reaches its limit, so IF wins next cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      PRIO_D: begin
        if (espera_nxt_s == ESPERA_MAX) begin
          state_nxt_s = PRIO_IF;
        end else begin
          state_nxt_s = PRIO_D;
        end
      end
      PRIO_IF: begin
        if (gnt_s[PORT_IF]) begin
          state_nxt_s = PRIO_D;
        end else begin
          state_nxt_s = PRIO_IF;
        end
      end
      default: state_nxt_s = PRIO_D;
    endcase
  end

  // grant and ROM address outputs
  always_comb begin
    if_gnt = gnt_s[PORT_IF];
    d_gnt  = gnt_s[PORT_D];
    if (gnt_s[PORT_IF]) begin
      sel_addr_s = if_addr;
    end else begin
      sel_addr_s = d_addr;
    end
    if (rst) begin
      rom_addr = '0;
    end else if (gnt_s != 2'b00) begin
      rom_addr = sel_addr_s;
    end else begin
      rom_addr = last_addr_r;
    end
  end

  rom_arb_resp #(.ANCHO(ANCHO)) u_resp_if (
    .clk     (clk),
    .rst     (rst),
    .capture (gnt_s[PORT_IF]),
    .din     (rom_dout),
    .rvalid  (if_rvalid),
    .rdata   (if_rdata)
  );

  rom_arb_resp #(.ANCHO(ANCHO)) u_resp_d (
    .clk     (clk),
    .rst     (rst),
    .capture (gnt_s[PORT_D]),
    .din     (rom_dout),
    .rvalid  (d_rvalid),
    .rdata   (d_rdata)
  );

`ifdef ROM_ARBITER_STATS_EN
  // saturating grant and contention counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_gnt   <= 16'd0;
      stat_d_gnt    <= 16'd0;
      stat_conflict <= 16'd0;
    end else begin
      stat_if_gnt   <= gnt_s[PORT_IF] ? sat_inc16(stat_if_gnt) : stat_if_gnt;
      stat_d_gnt    <= gnt_s[PORT_D] ? sat_inc16(stat_d_gnt) : stat_d_gnt;
      stat_conflict <= (if_req && d_req) ? sat_inc16(stat_conflict) : stat_conflict;
    end
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: two instances (MAX_ESPERA 4 and 1) share
// directed stimulus; responses are checked by a decoupled monitor.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [9:0]  if_addr = 10'd0;
  logic        d_req = 1'b0;
  logic [9:0]  d_addr = 10'd0;

  logic        if_gnt0, if_rvalid0, d_gnt0, d_rvalid0;
  logic [31:0] if_rdata0, d_rdata0, rom_dout0;
  logic [9:0]  rom_addr0;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1;
  logic [31:0] if_rdata1, d_rdata1, rom_dout1;
  logic [9:0]  rom_addr1;
`ifdef ROM_ARBITER_STATS_EN
  logic [15:0] st_if0, st_d0, st_c0, st_if1, st_d1, st_c1;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int vn = 0;
  logic [31:0] exp_q [4][$];
  logic [31:0] last_a [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
  logic        rv_a [4];
  logic [31:0] rd_a [4];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [9:0] a);
    case (a)
      10'h010: return 32'hDEADBEEF;
      10'h000: return 32'h00000011;
      10'h001: return 32'h00000022;
      10'h002: return 32'h00000033;
      default: return 32'hC0DE0000 ^ {22'd0, a};
    endcase
  endfunction

  assign rom_dout0 = rom_f(rom_addr0);
  assign rom_dout1 = rom_f(rom_addr1);

  rom_arbiter #(.ANCHO(32), .LARGO(1024), .MAX_ESPERA(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0),
    .if_rvalid(if_rvalid0), .if_rdata(if_rdata0),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt0),
    .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .rom_addr(rom_addr0), .rom_dout(rom_dout0)
`ifdef ROM_ARBITER_STATS_EN
    , .stat_if_gnt(st_if0), .stat_d_gnt(st_d0), .stat_conflict(st_c0)
`endif
  );

  rom_arbiter #(.ANCHO(32), .LARGO(1024), .MAX_ESPERA(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt1),
    .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .rom_addr(rom_addr1), .rom_dout(rom_dout1)
`ifdef ROM_ARBITER_STATS_EN
    , .stat_if_gnt(st_if1), .stat_d_gnt(st_d1), .stat_conflict(st_c1)
`endif
  );

  assign rv_a[0] = if_rvalid0;
  assign rv_a[1] = d_rvalid0;
  assign rv_a[2] = if_rvalid1;
  assign rv_a[3] = d_rvalid1;
  assign rd_a[0] = if_rdata0;
  assign rd_a[1] = d_rdata0;
  assign rd_a[2] = if_rdata1;
  assign rd_a[3] = d_rdata1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One directed cycle: drive inputs, check grants/rom_addr, queue expected responses.
  task automatic vec(input logic r, input logic ir, input logic [9:0] ia,
                     input logic dr, input logic [9:0] da,
                     input logic ig0, input logic dg0, input logic [9:0] ra0,
                     input logic ig1, input logic dg1, input logic [9:0] ra1);
    @(posedge clk);
    #1;
    rst = r; if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
    #1;
    chk($sformatf("v%0d if_gnt(m4)", vn), {31'd0, if_gnt0}, {31'd0, ig0});
    chk($sformatf("v%0d d_gnt(m4)", vn), {31'd0, d_gnt0}, {31'd0, dg0});
    chk($sformatf("v%0d rom_addr(m4)", vn), {22'd0, rom_addr0}, {22'd0, ra0});
    chk($sformatf("v%0d if_gnt(m1)", vn), {31'd0, if_gnt1}, {31'd0, ig1});
    chk($sformatf("v%0d d_gnt(m1)", vn), {31'd0, d_gnt1}, {31'd0, dg1});
    chk($sformatf("v%0d rom_addr(m1)", vn), {22'd0, rom_addr1}, {22'd0, ra1});
    if (ig0) exp_q[0].push_back(rom_f(ia));
    if (dg0) exp_q[1].push_back(rom_f(da));
    if (ig1) exp_q[2].push_back(rom_f(ia));
    if (dg1) exp_q[3].push_back(rom_f(da));
    vn++;
  endtask

  // Monitor: pop and compare on rvalid, otherwise rdata must hold.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (rv_a[p] === 1'b1) begin
        if (exp_q[p].size() == 0) begin
          chk($sformatf("unexpected rvalid port%0d", p), 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          e = exp_q[p].pop_front();
          chk($sformatf("rdata port%0d", p), rd_a[p], e);
          last_a[p] = e;
        end
      end else begin
        chk($sformatf("rdata hold port%0d", p), rd_a[p], last_a[p]);
      end
    end
    if (rst) begin
      for (int p = 0; p < 4; p++) last_a[p] = 32'd0;
    end
  end

  initial begin
    // reset with both requesting: no grants, rom_addr 0
    vec(1'b1, 1'b1, 10'h030, 1'b1, 10'h020, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000);
    vec(1'b1, 1'b1, 10'h030, 1'b1, 10'h020, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000);
    // single D request, then idle with rom_addr held
    vec(1'b0, 1'b0, 10'h000, 1'b1, 10'h010, 1'b0, 1'b1, 10'h010, 1'b0, 1'b1, 10'h010);
    vec(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h010, 1'b0, 1'b0, 10'h010);
    vec(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000);
    // 10 contention cycles: m4 -> D D D D IF D D D D IF, m1 -> D IF alternating
    for (int k = 0; k < 10; k++) begin
      logic ig0, ig1;
      ig0 = (k == 4 || k == 9);
      ig1 = (k % 2 == 1);
      vec(1'b0, 1'b1, 10'h030, 1'b1, 10'h020,
          ig0, !ig0, ig0 ? 10'h030 : 10'h020,
          ig1, !ig1, ig1 ? 10'h030 : 10'h020);
    end
    vec(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h030, 1'b0, 1'b0, 10'h030);
`ifdef ROM_ARBITER_STATS_EN
    chk("stat_conflict(m4)", {16'd0, st_c0}, 32'd10);
    chk("stat_d_gnt(m4)", {16'd0, st_d0}, 32'd8);
    chk("stat_if_gnt(m4)", {16'd0, st_if0}, 32'd2);
    chk("stat_conflict(m1)", {16'd0, st_c1}, 32'd10);
    chk("stat_d_gnt(m1)", {16'd0, st_d1}, 32'd5);
    chk("stat_if_gnt(m1)", {16'd0, st_if1}, 32'd5);
`endif
    // IF back-to-back at 0,1,2
    vec(1'b0, 1'b1, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000);
    vec(1'b0, 1'b1, 10'h001, 1'b0, 10'h000, 1'b1, 1'b0, 10'h001, 1'b1, 1'b0, 10'h001);
    vec(1'b0, 1'b1, 10'h002, 1'b0, 10'h000, 1'b1, 1'b0, 10'h002, 1'b1, 1'b0, 10'h002);
    vec(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h002, 1'b0, 1'b0, 10'h002);
    // IF withdrawn before grant; m1 keeps PRIO_IF until IF next requests
    vec(1'b0, 1'b1, 10'h030, 1'b1, 10'h020, 1'b0, 1'b1, 10'h020, 1'b0, 1'b1, 10'h020);
    vec(1'b0, 1'b0, 10'h030, 1'b1, 10'h021, 1'b0, 1'b1, 10'h021, 1'b0, 1'b1, 10'h021);
    vec(1'b0, 1'b1, 10'h031, 1'b1, 10'h022, 1'b0, 1'b1, 10'h022, 1'b1, 1'b0, 10'h031);
    vec(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h022, 1'b0, 1'b0, 10'h031);
    // contention until m4 is about to favour IF, then reset mid-operation
    vec(1'b0, 1'b1, 10'h050, 1'b1, 10'h040, 1'b0, 1'b1, 10'h040, 1'b0, 1'b1, 10'h040);
    vec(1'b0, 1'b1, 10'h050, 1'b1, 10'h040, 1'b0, 1'b1, 10'h040, 1'b1, 1'b0, 10'h050);
    vec(1'b0, 1'b1, 10'h050, 1'b1, 10'h040, 1'b0, 1'b1, 10'h040, 1'b0, 1'b1, 10'h040);
    vec(1'b0, 1'b1, 10'h050, 1'b1, 10'h040, 1'b0, 1'b1, 10'h040, 1'b1, 1'b0, 10'h050);
    vec(1'b1, 1'b1, 10'h050, 1'b1, 10'h040, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000);
    vec(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000);
    vec(1'b0, 1'b1, 10'h050, 1'b1, 10'h040, 1'b0, 1'b1, 10'h040, 1'b0, 1'b1, 10'h040);
    for (int k = 0; k < 3; k++) begin
      vec(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h040, 1'b0, 1'b0, 10'h040);
    end
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("pending responses port%0d", p), exp_q[p].size(), 32'd0);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
